// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED decode sequencer.
//   state_t     : sequencer FSM states
//   FLAG_*      : 2-bit result status flags placed in result bits [15:14]
//   POS_P*      : bit positions of the parity bits inside a stored word
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    LATCH,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_SGL  = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

endpackage

// File: rtl/hamming_decode_sequencer_secded.sv
// Combinational SECDED decoder for one 16-bit stored word.
//   w     in  16 : stored word, p0 at bit 0, p1/p2/p4/p8 at bits 1/2/4/8
//   data  out 11 : recovered message d11..d1 (corrected when possible)
//   flags out 2  : FLAG_NONE / FLAG_SGL / FLAG_DBL
module secded_decode
  import hamming_pkg::*;
(
  input  logic [15:0] w,
  output logic [10:0] data,
  output logic [1:0]  flags
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (w[k]) syn = syn ^ 4'(k);
    end
    par   = ^w;
    fixed = w;
    flags = FLAG_NONE;
    if (par) begin
      // Syndrome 0 with odd parity points at p0 itself; the data is untouched.
      fixed[syn] = ~w[syn];
      flags      = FLAG_SGL;
    end else if (syn != 4'd0) begin
      flags = FLAG_DBL;
    end
    data = {fixed[15:9], fixed[7:5], fixed[3]};
  end

endmodule

// File: rtl/hamming_decode_sequencer.sv
// Sequencer that walks N_WORDS SECDED words in data memory, decodes each one
// and writes {flags, 3'b000, d11..d1} back as two bytes.
//   clk, reset   : single clock, synchronous active-high reset; release starts a run
//   mem_addr     : byte address for the current read or write
//   mem_wr_en    : write strobe (WR_LO / WR_HI only)
//   mem_wr_data  : byte to write
//   mem_rd_data  : read byte, valid one cycle after mem_addr
//   done         : run complete, held until reset
//   single_cnt   : words corrected this run (saturating)
//   double_cnt   : words flagged uncorrectable this run (saturating)
module hamming_decode_sequencer
  import hamming_pkg::*;
#(
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned N_WORDS  = 15,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          done,
  output logic [3:0]    single_cnt,
  output logic [3:0]    double_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [7:0]  lo_byte;
  logic [10:0] res_data;
  logic [1:0]  res_flags;
  logic [10:0] dec_data;
  logic [1:0]  dec_flags;
  logic        last_word;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;

  assign last_word = (idx == 4'(N_WORDS - 1));
  assign src_addr  = AW'(SRC_BASE) + AW'({idx, 1'b0});
  assign dst_addr  = AW'(DST_BASE) + AW'({idx, 1'b0});

  // The high byte arrives on the read port during LATCH, so decode straight
  // from the port rather than waiting another cycle to register it.
  secded_decode u_dec (
    .w     ({mem_rd_data, lo_byte}),
    .data  (dec_data),
    .flags (dec_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_addr    = src_addr;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    unique case (state)
      IDLE:  state_nxt = RD_LO;
      RD_LO: state_nxt = RD_HI;
      RD_HI: begin
        mem_addr  = src_addr + AW'(1);
        state_nxt = LATCH;
      end
      LATCH: state_nxt = WR_LO;
      WR_LO: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = res_data[7:0];
        state_nxt   = WR_HI;
      end
      WR_HI: begin
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = {res_flags, 3'b000, res_data[10:8]};
        state_nxt   = last_word ? DONE : RD_LO;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      lo_byte    <= '0;
      res_data   <= '0;
      res_flags  <= FLAG_NONE;
      single_cnt <= '0;
      double_cnt <= '0;
    end else begin
      unique case (state)
        RD_HI: lo_byte <= mem_rd_data;
        LATCH: begin
          res_data  <= dec_data;
          res_flags <= dec_flags;
        end
        WR_HI: begin
          if (res_flags == FLAG_SGL && single_cnt != 4'hF) single_cnt <= single_cnt + 4'd1;
          if (res_flags == FLAG_DBL && double_cnt != 4'hF) double_cnt <= double_cnt + 4'd1;
          if (!last_word) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_decode_sequencer.sv
// Directed bench for hamming_decode_sequencer with a behavioural byte memory.
module tb_hamming_decode_sequencer;

  localparam int unsigned SRC = 30;
  localparam int unsigned DST = 0;
  localparam int unsigned NW  = 15;
  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       done;
  logic [3:0] single_cnt;
  logic [3:0] double_cnt;

  logic [7:0]  mem [0:255];
  logic [15:0] src_w [NW];
  logic [15:0] exp_r [NW];
  int unsigned wr_count;
  int unsigned bad_wr;
  int          tests;
  int          fails;

  always #5 clk = ~clk;

  hamming_decode_sequencer #(
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .N_WORDS  (NW),
    .AW       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .done        (done),
    .single_cnt  (single_cnt),
    .double_cnt  (double_cnt)
  );

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count++;
      if (int'(mem_addr) > int'(DST + 2 * NW - 1)) bad_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic        x;
    w = '0;
    for (int b = 0; b < 11; b++) w[DPOS[b]] = d[b];
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) x = x ^ w[k];
      w[p] = x;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] w);
    logic [10:0] d;
    for (int b = 0; b < 11; b++) d[b] = w[DPOS[b]];
    return d;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < int'(NW); i++) begin
      mem[SRC + 2 * i]     = src_w[i][7:0];
      mem[SRC + 2 * i + 1] = src_w[i][15:8];
      mem[DST + 2 * i]     = 8'hEE;
      mem[DST + 2 * i + 1] = 8'hEE;
    end
  endtask

  task automatic hold_reset(input string name);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, " rst addr"}, 32'(mem_addr), SRC);
    check({name, " rst wr_en"}, 32'(mem_wr_en), 0);
    check({name, " rst wr_data"}, 32'(mem_wr_data), 0);
    check({name, " rst done"}, 32'(done), 0);
    check({name, " rst single"}, 32'(single_cnt), 0);
    check({name, " rst double"}, 32'(double_cnt), 0);
    wr_count = 0;
    bad_wr   = 0;
  endtask

  task automatic run_and_check(input string name, input int exp_s, input int exp_d);
    int done_cyc;
    hold_reset(name);
    @(negedge clk);
    reset = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cyc = c;
    end
    check({name, " done cycle"}, 32'(done_cyc), 75);
    for (int i = 0; i < int'(NW); i++)
      check($sformatf("%s result %0d", name, i), {16'h0, mem[DST + 2 * i + 1], mem[DST + 2 * i]},
            {16'h0, exp_r[i]});
    check({name, " single_cnt"}, 32'(single_cnt), 32'(exp_s));
    check({name, " double_cnt"}, 32'(double_cnt), 32'(exp_d));
    repeat (4) @(posedge clk);
    #1;
    check({name, " done held"}, 32'(done), 1);
    check({name, " write count"}, wr_count, 30);
    check({name, " stray writes"}, bad_wr, 0);
  endtask

  task automatic make_random(output int ns, output int nd);
    logic [10:0] d;
    logic [15:0] c;
    int          j;
    ns = 0;
    nd = 0;
    for (int i = 0; i < int'(NW); i++) begin
      d = 11'($urandom_range(2047));
      c = encode(d);
      c[i] = ~c[i];
      if ($urandom_range(3) == 0) begin
        do j = $urandom_range(15); while (j == i);
        c[j] = ~c[j];
        exp_r[i] = {2'b10, 3'b000, raw_data(c)};
        nd++;
      end else begin
        exp_r[i] = {2'b01, 3'b000, d};
        ns++;
      end
      src_w[i] = c;
    end
  endtask

  initial begin
    int ns;
    int nd;
    tests    = 0;
    fails    = 0;
    wr_count = 0;
    bad_wr   = 0;

    // Directed words from hand decoding; remaining words are clean zeros.
    for (int i = 0; i < int'(NW); i++) begin
      src_w[i] = 16'h0000;
      exp_r[i] = 16'h0000;
    end
    src_w[1] = 16'hFFFF; exp_r[1] = 16'h07FF;
    src_w[2] = 16'h0020; exp_r[2] = 16'h4000;
    src_w[3] = 16'h0001; exp_r[3] = 16'h4000;
    src_w[4] = 16'h0028; exp_r[4] = 16'h8003;
    load_mem();
    run_and_check("directed", 2, 1);

    make_random(ns, nd);
    load_mem();
    run_and_check("random", ns, nd);

    // Abort during word 4 (cycle 22), then let a full run complete.
    make_random(ns, nd);
    load_mem();
    hold_reset("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort write count", wr_count, 8);
    check("abort done", 32'(done), 0);
    check("abort wr_en", 32'(mem_wr_en), 0);
    check("abort word3 hi", 32'(mem[DST + 7]), 32'(exp_r[3][15:8]));
    check("abort word4 untouched", 32'(mem[DST + 8]), 32'hEE);
    repeat (3) @(posedge clk);
    #1;
    check("abort held writes", wr_count, 8);
    run_and_check("restart", ns, nd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming_decode_sequencer.md
# hamming_decode_sequencer

Program-2 controller: on release of `reset`, walks 15 stored 16-bit SECDED-protected words in data memory and corrects single-bit errors. It flags double-bit errors, writes the 11-bit recovered messages with status flags back to memory, and raises `done`. It sits between the top-level start/done handshake and the data-memory port, and owns that port for the whole run.

## Interface
- `SRC_BASE`, default 30: byte address of word 0 low byte; word i occupies bytes SRC_BASE+2i (low) and SRC_BASE+2i+1 (high).
- `DST_BASE`, default 0: byte address of result 0 low byte; result i occupies bytes DST_BASE+2i (low) and DST_BASE+2i+1 (high).
- `N_WORDS`, default 15: number of words per run.
- `AW`, default 8: memory address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high. It clears all state, and its falling edge starts a run.
- `mem_addr` out AW: byte address for read or write.
- `mem_wr_en` out 1: write strobe for `mem_wr_data` to `mem_addr` at this edge.
- `mem_wr_data` out 8: write byte.
- `mem_rd_data` in 8: read byte. It is valid in the cycle after `mem_addr` is presented (1-cycle registered read).
- `done` out 1: run complete.
- `single_cnt` out 4: number of words corrected this run.
- `double_cnt` out 4: number of words flagged uncorrectable this run.

## Operation
- **Input word layout.** The input word is w = {high byte, low byte}.
  - w[0] = p0, overall parity.
  - w[1], w[2], w[4], w[8] = p1, p2, p4, p8.
  - Data sits at w[3] = d1, w[7:5] = d4:d2, w[15:9] = d11:d5.
- **Decode.**
  - s[3:0] = XOR of the indices k (1..15) of all set bits w[k].
  - P = XOR of all 16 bits.
- **Classification.**
  - P=0, s=0: no error. flags = 2'b00.
  - P=1: single error. Invert w[s]; s=0 means p0 itself, so the data is unchanged. flags = 2'b01.
  - P=0, s≠0: double error. Data is passed through uncorrected. flags = 2'b10.
- **Result word.** {flags[1:0], 3'b000, d11..d1}. The result high byte goes to DST_BASE+2i+1 and the low byte to DST_BASE+2i.
- **FSM states.** IDLE, RD_LO, RD_HI, LATCH, WR_LO, WR_HI, DONE.
  - IDLE: held while `reset`=1. The first cycle with `reset`=0 goes to RD_LO with word index i=0.
  - RD_LO: mem_addr = SRC_BASE+2i.
  - RD_HI: mem_addr = SRC_BASE+2i+1; capture the low byte.
  - LATCH: capture the high byte; decode.
  - WR_LO: write the result low byte.
  - WR_HI: write the result high byte, then update the counters.
    - If i = N_WORDS−1, go to DONE.
    - Otherwise increment i and go to RD_LO.
  - DONE: `done`=1, no memory activity, held until `reset`.
- **Counters.** Each counter saturates at 15 and never wraps. A no-error word increments neither counter.
- **Write strobe.** `mem_wr_en` is high only in WR_LO and WR_HI.

## Timing
- **Reset values.** While `reset`=1 and on the edge after it: state=IDLE, i=0, `mem_addr`=SRC_BASE, `mem_wr_en`=0, `mem_wr_data`=0, `done`=0, `single_cnt`=0, `double_cnt`=0.
- **Per-word cost.** 5 cycles per word. Cycle numbering starts at 0 = the first cycle with `reset` low.
  - Word i reads in cycles 5i and 5i+1.
  - Word i writes in cycles 5i+3 and 5i+4.
- **Completion.** `done` rises in cycle 5·N_WORDS (75 by default) and stays high.
- **Reset mid-run.** The run aborts the next edge with no further writes. Bytes already written stay in memory. On release the run restarts at word 0.
- **Reset while in DONE.** Clears `done` and the counters.
- **Address overlap.** Source and destination address ranges must not overlap. The block does not check for overlap.

## Structure
- **Package `hamming_pkg`.**
  - FSM state enum.
  - Flag constants: `FLAG_NONE`=2'b00, `FLAG_SGL`=2'b01, `FLAG_DBL`=2'b10.
  - Bit-position constants for p0/p1/p2/p4/p8.
- **Sub-module `secded_decode`.** Purely combinational.
  - Input: 16-bit w.
  - Outputs: 11-bit data and 2-bit flags.
  - The FSM instantiates one copy of it and registers its outputs in LATCH.

## Test plan
- **Clean word.** Stored 0x0000 → result 0x0000 (high 0x00, low 0x00). `single_cnt`=0, `double_cnt`=0.
- **Clean word.** Stored 0xFFFF (d=0x7FF) → result 0x07FF.
- **Single data-bit error.** Stored 0x0020 (bit 5 flipped from 0x0000) → result 0x4000. `single_cnt` increments.
- **Single parity-bit error.** Stored 0x0001 (p0 flipped) → result 0x4000.
- **Double error.** Stored 0x0028 (bits 3 and 5 flipped) → result 0x8003. `double_cnt` increments.
- **Full 15-word run.** Each word i has bit i flipped, plus a random second flip on about 25% of words. Every result matches a reference model, `done` rises in cycle 75, and no write goes outside DST_BASE..DST_BASE+29.
- **Reset mid-run.** Assert `reset` in cycle 22 (word 4) → writes stop, `done`=0. After release, all 15 results are correct and `done` rises 75 cycles later.
